program_sequencer_nested: RTL

- Parametrised next-generation program sequencer: drives the program-memory address and keeps the registered program counter.
- Adds a hardware loop stack, so loops can nest up to LOOP_DEPTH levels.
- Each loop instruction sets its own body length (ir[3:0]) and iteration count (data_bus).
- Sits between the instruction decoder (jmp, jmp_nz, dont_jmp, ir) and program memory; exports the active loop count to the data path.

---
 rtl/ps_pkg.sv | 29 ++
 rtl/ps_loop_stack.sv | 56 +++++
 rtl/program_sequencer_nested.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ps_pkg.sv
// Shared definitions for the nested-loop program sequencer: loop opcode,
// loop-stack entry layout and the pm_addr source-select encoding.
// The entry struct is sized for the default address/count widths; builds
// that widen ADDR_W or CNT_W must widen PS_ADDR_W / PS_CNT_W to match.
package ps_pkg;

    localparam int unsigned PS_ADDR_W      = 8;
    localparam int unsigned PS_CNT_W       = 4;
    localparam logic [3:0]  PS_LOOP_OPCODE = 4'd3;

    // One hardware-loop frame: first body address, last body address, remaining repeats
    typedef struct packed {
        logic [PS_ADDR_W-1:0] start_addr;
        logic [PS_ADDR_W-1:0] end_addr;
        logic [PS_CNT_W-1:0]  count;
    } loop_entry_t;

    // pm_addr source, listed from highest to lowest priority
    typedef enum logic [2:0] {
        SEL_RESET  = 3'd0,
        SEL_BRK    = 3'd1,
        SEL_REPEAT = 3'd2,
        SEL_EXIT   = 3'd3,
        SEL_JMP    = 3'd4,
        SEL_JNZ    = 3'd5,
        SEL_SEQ    = 3'd6
    } pm_sel_e;

endpackage

// File: rtl/ps_loop_stack.sv
// LIFO of loop frames with push, pop and decrement-top; exposes the top
// frame (all zeros when empty), full/empty flags and the occupancy level.
module ps_loop_stack
    import ps_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  loop_entry_t      push_entry,
    input  logic             pop,
    input  logic             dec_top,
    output loop_entry_t      top,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NUM_SLOTS = 1 << IDX_W;

    loop_entry_t      mem [NUM_SLOTS];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    // Slot addressing and status derived from the occupancy count
    always_comb begin
        wr_idx  = IDX_W'(level);
        top_idx = IDX_W'(level - LVL_W'(1));
        full    = (level == LVL_W'(DEPTH));
        empty   = (level == '0);
        top     = empty ? '0 : mem[top_idx];
    end

    // Stack storage and level; callers never request two operations at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_idx] <= push_entry;
                level       <= level + LVL_W'(1);
            end else if (pop && !empty) begin
                level <= level - LVL_W'(1);
            end else if (dec_top && !empty) begin
                mem[top_idx].count <= mem[top_idx].count - PS_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/program_sequencer_nested.sv
// Program sequencer with a nested hardware-loop stack. Drives pm_addr
// combinationally, registers pc, and reports the active loop count.
// Optional macro PS_LOOP_BREAK_EN adds the brk input (exit innermost loop).
module program_sequencer_nested
    import ps_pkg::*;
#(
    parameter int unsigned ADDR_W      = PS_ADDR_W,
    parameter int unsigned JMP_W       = 4,
    parameter int unsigned CNT_W       = PS_CNT_W,
    parameter int unsigned LOOP_DEPTH  = 4,
    parameter logic [3:0]  LOOP_OPCODE = PS_LOOP_OPCODE
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             jmp,
    input  logic                             jmp_nz,
    input  logic                             dont_jmp,
    input  logic [JMP_W-1:0]                 jmp_addr,
    input  logic [7:0]                       ir,
    input  logic [CNT_W-1:0]                 data_bus,
`ifdef PS_LOOP_BREAK_EN
    input  logic                             brk,
`endif
    output logic [ADDR_W-1:0]                pm_addr,
    output logic [ADDR_W-1:0]                pc,
    output logic [7:0]                       from_PS,
    output logic [$clog2(LOOP_DEPTH+1)-1:0]  loop_level,
    output logic                             loop_err
);

    localparam int unsigned LVL_W = $clog2(LOOP_DEPTH + 1);

    loop_entry_t        top;
    loop_entry_t        push_entry;
    logic               full;
    logic               empty;
    logic [LVL_W-1:0]   level;

    logic               is_loop;
    logic               at_end;
    logic               cnt_zero;
    logic               brk_take;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               dec_top;
    logic               err_set;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  top_end;
    logic [ADDR_W-1:0]  jmp_tgt;
    pm_sel_e            sel;

`ifdef PS_LOOP_BREAK_EN
    // Break only acts on a live loop; with an empty stack it is ignored
    assign brk_take = brk && !empty;
`else
    assign brk_take = 1'b0;
`endif

    // Decode loop-end condition and stack control for this cycle
    always_comb begin
        is_loop  = (ir[7:4] == LOOP_OPCODE);
        pc_inc   = pc + ADDR_W'(1);
        top_end  = ADDR_W'(top.end_addr);
        jmp_tgt  = {jmp_addr, {(ADDR_W - JMP_W){1'b0}}};
        at_end   = !empty && (pc == top_end);
        cnt_zero = (top.count == '0);

        push_req = is_loop && !at_end && !brk_take;
        push     = push_req && !full;
        pop      = brk_take || (at_end && cnt_zero);
        dec_top  = at_end && !cnt_zero && !brk_take;
        err_set  = (is_loop && at_end) || (push_req && full);

        push_entry            = '0;
        push_entry.start_addr = PS_ADDR_W'(pc_inc);
        push_entry.end_addr   = PS_ADDR_W'(pc_inc + ADDR_W'(ir[3:0]));
        push_entry.count      = PS_CNT_W'(data_bus);
    end

    // Prioritised source select for the next program-memory address
    always_comb begin
        sel = SEL_SEQ;
        if (!reset_n) begin
            sel = SEL_RESET;
        end else if (brk_take) begin
            sel = SEL_BRK;
        end else if (at_end && !cnt_zero) begin
            sel = SEL_REPEAT;
        end else if (at_end) begin
            sel = SEL_EXIT;
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (jmp_nz && !dont_jmp) begin
            sel = SEL_JNZ;
        end
    end

    // Next-address mux
    always_comb begin
        pm_addr = pc_inc;
        case (sel)
            SEL_RESET:  pm_addr = '0;
            SEL_BRK:    pm_addr = top_end + ADDR_W'(1);
            SEL_REPEAT: pm_addr = ADDR_W'(top.start_addr);
            SEL_EXIT:   pm_addr = pc_inc;
            SEL_JMP:    pm_addr = jmp_tgt;
            SEL_JNZ:    pm_addr = jmp_tgt;
            default:    pm_addr = pc_inc;
        endcase
    end

    // Active count exported to the data path
    always_comb begin
        from_PS    = 8'(top.count);
        loop_level = level;
    end

    // Program counter follows the selected address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else begin
            pc <= pm_addr;
        end
    end

    // Sticky loop error: overflow or loop instruction on an end address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_err <= 1'b0;
        end else if (err_set) begin
            loop_err <= 1'b1;
        end
    end

    ps_loop_stack #(
        .DEPTH (LOOP_DEPTH),
        .LVL_W (LVL_W)
    ) u_stack (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .dec_top    (dec_top),
        .top        (top),
        .full       (full),
        .empty      (empty),
        .level      (level)
    );

endmodule
